// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; DEPTH must be a power of 2.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [LEVEL_W-1:0]        level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO and registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4167,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              resetb,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [UART_BAUD_W-1:0] BAUD_LAST = UART_BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]       BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_t               state, state_next;
  logic [UART_BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]          bit_cnt, bit_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      tx_next;
  logic                      pop;
  logic                      load;
  logic                      full;
  logic                      empty;
  logic                      baud_done;
`ifdef UART_TX_PARITY_EN
  logic                      parity, parity_next;
`endif

  uart_tx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W ($clog2(FIFO_DEPTH+1))
  ) u_fifo (
    .clock   (clock),
    .resetb  (resetb),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign in_ready  = !full;
  assign busy      = (state != IDLE) || !empty;
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    load       = 1'b0;
    pop        = 1'b0;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    // The baud counter free-runs in every bit state and wraps at the bit boundary.
    if (state != IDLE) baud_next = baud_done ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE:  load = !empty;
      START: if (baud_done) begin
        state_next = DATA;
        bit_next   = '0;
      end
      DATA:  if (baud_done) begin
        shift_next = shift >> 1;
        bit_next   = bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (bit_cnt == BIT_LAST) state_next = PARITY;
`else
        if (bit_cnt == BIT_LAST) state_next = STOP;
`endif
      end
      PARITY: if (baud_done) state_next = STOP;
      STOP:  if (baud_done) begin
        if (!empty) load = 1'b1;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Back-to-back frames reload straight from the stop bit with no idle gap.
    if (load) begin
      pop        = 1'b1;
      shift_next = fifo_data;
      state_next = START;
`ifdef UART_TX_PARITY_EN
      parity_next = ^fifo_data;
`endif
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame table, burst/back-to-back, reset mid-frame,
// with a mid-bit receiver feeding a frame scoreboard.
module tb_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CLK_DIV;

  logic       clock    = 1'b0;
  logic       resetb   = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = '0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int vectors     = 0;
  int miscompares = 0;
  int rx_frames   = 0;

  // Frame bit i is the tx level during bit period i (bit 0 = start bit).
  logic [FB-1:0] exp_q[$];

  typedef struct {
    logic [7:0]    data;
    logic [FB-1:0] frame;
  } vec_t;
  vec_t vecs[6];

  uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Call just after a negedge; returns at the negedge following the accepting edge.
  task automatic push_byte(input logic [7:0] d, output int stall);
    stall    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && stall < 2000) begin
      @(negedge clock);
      stall++;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Bit-level receiver: samples mid-bit, drops a frame cut by reset.
  initial begin
    bit            rx_busy = 1'b0;
    int            rx_cnt  = 0;
    logic [FB-1:0] rx_bits = '0;
    forever begin
      @(negedge clock);
      if (!resetb) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (tx === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
          rx_bits[rx_cnt / CLK_DIV] = tx;
          if (rx_cnt / CLK_DIV == FB - 1) begin
            rx_busy = 1'b0;
            rx_frames++;
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL rx_unexpected: got frame 0x%0h, expected none", rx_bits);
            end else begin
              check($sformatf("rx_frame%0d", rx_frames), 32'(rx_bits), 32'(exp_q.pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    int stall;
    int cyc;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'h54A};
    vecs[1] = '{8'hFF, 11'h5FE};
    vecs[2] = '{8'h00, 11'h400};
    vecs[3] = '{8'h81, 11'h502};
    vecs[4] = '{8'h07, 11'h60E};
    vecs[5] = '{8'h03, 11'h406};
`else
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'hFF, 10'h3FE};
    vecs[2] = '{8'h00, 10'h200};
    vecs[3] = '{8'h81, 10'h302};
    vecs[4] = '{8'h07, 10'h20E};
    vecs[5] = '{8'h03, 10'h206};
`endif

    // reset with a push attempt held throughout
    resetb   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) @(negedge clock);
    check("reset_tx", 32'(tx), 1);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_level", 32'(level), 0);
    in_valid = 1'b0;
    resetb   = 1'b1;
    @(negedge clock);
    check("reset_push_ignored", 32'(level), 0);

    // single-byte frames from the table
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].frame);
      push_byte(vecs[i].data, stall);
      check($sformatf("v%0d_stall", i), stall, 0);
      check($sformatf("v%0d_tx_before_start", i), 32'(tx), 1);
      check($sformatf("v%0d_level_queued", i), 32'(level), 1);
      check($sformatf("v%0d_busy", i), 32'(busy), 1);
      @(negedge clock);
      check($sformatf("v%0d_tx_start", i), 32'(tx), 0);
      check($sformatf("v%0d_level_popped", i), 32'(level), 0);
      wait_idle(cyc);
      check($sformatf("v%0d_frame_cycles", i), cyc, FRAME_CYC);
    end

    // burst of six: fifth fills the FIFO, sixth stalls until byte 1 is popped
    for (int i = 0; i < 6; i++) exp_q.push_back(make_frame(8'(i)));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("burst_full_level", 32'(level), DEPTH);
        check("burst_in_ready_low", 32'(in_ready), 0);
      end
      push_byte(8'(i), stall);
      check($sformatf("burst_stall%0d", i), stall, (i == 5) ? FRAME_CYC - 3 : 0);
    end
    wait_idle(cyc);
    check("burst_tail_cycles", cyc, 5 * FRAME_CYC - 1);

    // edge patterns back-to-back
    exp_q.push_back(vecs[1].frame);
    exp_q.push_back(vecs[2].frame);
    push_byte(8'hFF, stall);
    push_byte(8'h00, stall);
    wait_idle(cyc);
    check("b2b_cycles", cyc, 2 * FRAME_CYC);

    // reset during data bit 3 of 0x3C with two bytes queued
    push_byte(8'h3C, stall);
    push_byte(8'h11, stall);
    push_byte(8'h22, stall);
    repeat (17) @(negedge clock);
    check("mid_frame_level", 32'(level), 2);
    check("mid_frame_busy", 32'(busy), 1);
    resetb = 1'b0;
    @(negedge clock);
    check("mid_reset_tx", 32'(tx), 1);
    check("mid_reset_level", 32'(level), 0);
    check("mid_reset_busy", 32'(busy), 0);
    check("mid_reset_in_ready", 32'(in_ready), 1);
    resetb = 1'b1;
    repeat (12) @(negedge clock);
    check("post_reset_tx_idle", 32'(tx), 1);
    check("post_reset_busy", 32'(busy), 0);
    exp_q.push_back(make_frame(8'h5A));
    push_byte(8'h5A, stall);
    wait_idle(cyc);
    check("post_reset_frame_cycles", cyc, FRAME_CYC + 1);

    // final report
    repeat (5) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frames_received", rx_frames, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
